// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for common-anode seven-segment digits.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned N_DIGITS  = 8,
    parameter int unsigned DWELL_CYC = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    output logic [6:0]            cathode,
    output logic [N_DIGITS-1:0]   anode,
    output logic                  frame_tick
);

    localparam int unsigned IDX_W   = $clog2(N_DIGITS);
    localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic                  pending;
    logic [4*N_DIGITS-1:0] shadow;
    logic [4*N_DIGITS-1:0] active;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_next;
    logic [N_DIGITS-1:0]   anode_lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'h3F;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5B;
            4'h3:    seg_decode = 7'h4F;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6D;
            4'h6:    seg_decode = 7'h7D;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

`ifdef SEG7_LZB_EN
    logic [N_DIGITS-1:0] lz;
    logic                run;

    // Walk from the most significant digit down; blanking stops at the first non-zero.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            run = run && (active[4*(N_DIGITS-1-k) +: 4] == 4'h0);
            lz[N_DIGITS-1-k] = run && (k != N_DIGITS-1);
        end
    end
`endif

    always_comb begin
        cur_digit = active[{idx, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        seg_next  = lz[idx] ? 7'h00 : seg_decode(cur_digit);
`else
        seg_next  = seg_decode(cur_digit);
`endif
        anode_lit = ~({{(N_DIGITS-1){1'b0}}, digit_en[idx]} << idx);
    end

    assign upd_ready = rst_n && !pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            shadow     <= '1;
            active     <= '1;
            anode      <= '1;
            cathode    <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            anode      <= '1;
            cathode    <= '1;
            if (upd_valid && !pending) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end
            case (state)
                BLANK: begin
                    if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                        state   <= SHOW;
                        cnt     <= '0;
                        anode   <= anode_lit;
                        cathode <= ~seg_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == CNT_W'(DWELL_CYC - 1)) begin
                        state <= BLANK;
                        cnt   <= '0;
                        if (idx == IDX_W'(N_DIGITS - 1)) begin
                            // Frame boundary: the only point where a new frame may take effect.
                            idx        <= '0;
                            frame_tick <= 1'b1;
                            if (pending) begin
                                active  <= shadow;
                                pending <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        anode   <= anode_lit;
                        cathode <= ~seg_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle dwell, 2-cycle blank).
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BK    = 2;
    localparam int SLOT  = BK + DW;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;
    logic        upd_valid;
    logic        upd_ready;
    logic [6:0]  cathode;
    logic [3:0]  anode;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .N_DIGITS (N),
        .DWELL_CYC(DW),
        .BLANK_CYC(BK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .digit_en  (digit_en),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .cathode   (cathode),
        .anode     (anode),
        .frame_tick(frame_tick)
    );

    typedef struct {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       tick;
        logic       ready;
    } exp_t;

    exp_t        expq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mq;
    logic [15:0] mact;
    logic [15:0] msh;
    logic        mpend;
    logic [6:0]  segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [15:0] f, input int i);
        logic [15:0] upper;
        int          d;
        upper = f >> (4 * i);
        d     = int'(upper & 16'hF);
        if (d > 9) return 7'h00;
`ifdef SEG7_LZB_EN
        if (i > 0 && upper == 16'h0) return 7'h00;
`endif
        return segtab[d];
    endfunction

    // Reference: position within the frame is a plain modulo counter.
    initial begin
        exp_t e;
        logic was_pend;
        int   slot;
        int   ph;
        mq = 0; mact = '1; msh = '1; mpend = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq = 0; mact = '1; msh = '1; mpend = 1'b0;
                e.anode = 4'hF; e.cathode = 7'h7F; e.tick = 1'b0; e.ready = 1'b0;
            end else begin
                was_pend = mpend;
                mq = (mq + 1) % FRAME;
                e.tick = (mq == 0);
                if (mq == 0 && was_pend) begin
                    mact  = msh;
                    mpend = 1'b0;
                end
                if (upd_valid && !was_pend) begin
                    msh   = digits_in;
                    mpend = 1'b1;
                end
                slot = mq / SLOT;
                ph   = mq % SLOT;
                e.anode   = 4'hF;
                e.cathode = 7'h7F;
                if (ph >= BK) begin
                    if (digit_en[slot]) e.anode = ~(4'b0001 << slot);
                    e.cathode = ~ref_seg(mact, slot);
                end
                e.ready = !mpend;
            end
            expq.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                e = expq.pop_front();
                chk("sb_anode",   16'(anode),      16'(e.anode));
                chk("sb_cathode", 16'(cathode),    16'(e.cathode));
                chk("sb_tick",    16'(frame_tick), 16'(e.tick));
                chk("sb_ready",   16'(upd_ready),  16'(e.ready));
            end
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        if (frame_tick !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_timeout: no frame_tick after %0d cycles, required within %0d", n, FRAME);
        end
    endtask

    task automatic load(input logic [15:0] v);
        upd_valid = 1'b1;
        digits_in = v;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; upd_valid = 1'b0; digits_in = '0; digit_en = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_anode",   16'(anode),     16'hF);
        chk("rst_cathode", 16'(cathode),   16'h7F);
        chk("rst_ready",   16'(upd_ready), 16'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("ready_idle", 16'(upd_ready), 16'h1);

        load(16'h1234);
        chk("ready_drop", 16'(upd_ready), 16'h0);
        wait_tick(n);
        chk("ready_back", 16'(upd_ready), 16'h1);
        repeat (2) @(negedge clk);
        chk("d0_anode",   16'(anode),   16'(4'b1110));
        chk("d0_cathode", 16'(cathode), 16'(7'b0011001));
        repeat (6) @(negedge clk);
        chk("d1_anode",   16'(anode),   16'(4'b1101));
        chk("d1_cathode", 16'(cathode), 16'(7'b0110000));
        wait_tick(n);
        wait_tick(n);
        chk("frame_len", 16'(n), 16'(FRAME));

        upd_valid = 1'b1; digits_in = 16'h1111;
        @(negedge clk);
        digits_in = 16'h2222;
        repeat (3) @(negedge clk);
        upd_valid = 1'b0;
        wait_tick(n);
        repeat (2) @(negedge clk);
        chk("bp_cathode", 16'(cathode), 16'(7'b1111001));
        wait_tick(n);

        digit_en = 4'b0101;
        load(16'hA0B9);
        wait_tick(n);
        wait_tick(n);
        chk("mask_frame_len", 16'(n), 16'(FRAME));
        repeat (2) @(negedge clk);
        chk("mask_d0_anode",   16'(anode),   16'(4'b1110));
        chk("mask_d0_cathode", 16'(cathode), 16'(7'b0010000));
        repeat (6) @(negedge clk);
        chk("mask_d1_anode", 16'(anode), 16'hF);
        repeat (6) @(negedge clk);
        chk("mask_d2_anode",   16'(anode),   16'(4'b1011));
        chk("mask_d2_cathode", 16'(cathode), 16'(7'b1000000));

        digit_en = 4'hF;
        wait_tick(n);
        load(16'h5555);
        repeat (13) @(negedge clk);
        chk("pre_rst_anode", 16'(anode), 16'(4'b1011));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_anode",   16'(anode),     16'hF);
        chk("midrst_cathode", 16'(cathode),   16'h7F);
        chk("midrst_ready",   16'(upd_ready), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_pend_clr", 16'(upd_ready), 16'h1);
        wait_tick(n);
        repeat (2) @(negedge clk);
        chk("midrst_blank", 16'(cathode), 16'h7F);

        load(16'h0070);
        wait_tick(n);
        repeat (2) @(negedge clk);
        chk("lzb_d0", 16'(cathode), 16'(7'b1000000));
        repeat (6) @(negedge clk);
        chk("lzb_d1", 16'(cathode), 16'(7'b1111000));
        repeat (6) @(negedge clk);
`ifdef SEG7_LZB_EN
        chk("lzb_d2", 16'(cathode), 16'h7F);
`else
        chk("lzb_d2", 16'(cathode), 16'(7'b1000000));
`endif
        repeat (6) @(negedge clk);
`ifdef SEG7_LZB_EN
        chk("lzb_d3", 16'(cathode), 16'h7F);
`else
        chk("lzb_d3", 16'(cathode), 16'(7'b1000000));
`endif

        repeat (400) begin
            @(negedge clk);
            upd_valid = ($urandom_range(0, 3) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; upd_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
